// File: rtl/dmac_bus_pkg.sv
// Shared types and constants for the DMAC subsystem bus: arbiter state,
// slave address windows and the registered read-select encoding.
package dmac_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } arb_state_e;

    // S0 memory: 0x0000-0x07FF, S1 register file: 0xF000-0xF01F
    localparam logic [ADDR_W-1:0] S0_BASE = 16'h0000;
    localparam logic [ADDR_W-1:0] S0_MASK = 16'hF800;
    localparam logic [ADDR_W-1:0] S1_BASE = 16'hF000;
    localparam logic [ADDR_W-1:0] S1_MASK = 16'hFFE0;

    // rsel = {s1_sel, s0_sel} captured one cycle earlier
    localparam logic [1:0] RSEL_NONE = 2'b00;
    localparam logic [1:0] RSEL_S0   = 2'b01;
    localparam logic [1:0] RSEL_S1   = 2'b10;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/dmac_bus_if.sv
// Bus signal bundle between the two masters, the bus fabric and the slaves.
// Handshake: a master raises req and holds addr/wr/dout stable; the access
// takes place in every cycle where req and its grant are both high. Writes
// complete in that cycle; read data appears on m_din the following cycle.
interface dmac_bus_if;
    import dmac_bus_pkg::*;

    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic              m0_grant;
    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic              m1_grant;
    logic [DATA_W-1:0] m_din;
    logic              s0_sel;
    logic              s1_sel;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s0_dout;
    logic [DATA_W-1:0] s1_dout;
    logic              bus_err;

    // Bus fabric view
    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_dout,
        input  m1_req, m1_wr, m1_addr, m1_dout,
        input  s0_dout, s1_dout,
        output m0_grant, m1_grant, m_din,
        output s0_sel, s1_sel, s_addr, s_wr, s_din, bus_err
    );

    // Environment view: masters plus slave devices
    modport master (
        output m0_req, m0_wr, m0_addr, m0_dout,
        output m1_req, m1_wr, m1_addr, m1_dout,
        output s0_dout, s1_dout,
        input  m0_grant, m1_grant, m_din,
        input  s0_sel, s1_sel, s_addr, s_wr, s_din, bus_err
    );

endinterface

// File: rtl/dmac_bus_arbiter.sv
// Two-master req/grant arbiter. M0 is the default owner; M1 takes the bus
// only when M0 is not requesting and keeps it until it drops its request.
module dmac_bus_arbiter
    import dmac_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    output logic       m0_grant,
    output logic       m1_grant,
    output arb_state_e state
);

    arb_state_e state_next;

    // State register, reset returns ownership to M0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= GNT_M0;
        else       state <= state_next;
    end

    // Next-state and Moore grant outputs
    always_comb begin
        state_next = state;
        m0_grant   = 1'b0;
        m1_grant   = 1'b0;
        case (state)
            GNT_M0: begin
                m0_grant = 1'b1;
                if (!m0_req && m1_req) state_next = GNT_M1;
            end
            GNT_M1: begin
                m1_grant = 1'b1;
                if (!m1_req) state_next = GNT_M0;
            end
            default: state_next = GNT_M0;
        endcase
    end

endmodule

// File: rtl/dmac_bus.sv
// Shared bus top: arbitration, master mux, address decode to the memory and
// the DMAC register file, one-cycle read return and unmapped-access error.
module dmac_bus
    import dmac_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    dmac_bus_if.slave  bus,
    output arb_state_e arb_state
);

    logic       m0_grant;
    logic       m1_grant;
    logic       acc_valid;
    logic       acc_wr;
    logic       hit_s0;
    logic       hit_s1;
    logic [1:0] rsel;

    dmac_bus_arbiter u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (bus.m0_req),
        .m1_req   (bus.m1_req),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .state    (arb_state)
    );

    assign bus.m0_grant = m0_grant;
    assign bus.m1_grant = m1_grant;

    // Route the granted master; an access is only live while its req is high
    always_comb begin
        bus.s_addr = bus.m0_addr;
        bus.s_din  = bus.m0_dout;
        acc_wr     = bus.m0_wr;
        acc_valid  = bus.m0_req;
        if (arb_state == GNT_M1) begin
            bus.s_addr = bus.m1_addr;
            bus.s_din  = bus.m1_dout;
            acc_wr     = bus.m1_wr;
            acc_valid  = bus.m1_req;
        end
    end

    // Address decode, gated by a live access
    always_comb begin
        hit_s0     = addr_hit(bus.s_addr, S0_BASE, S0_MASK);
        hit_s1     = addr_hit(bus.s_addr, S1_BASE, S1_MASK);
        bus.s0_sel = acc_valid && hit_s0;
        bus.s1_sel = acc_valid && hit_s1;
        bus.s_wr   = acc_valid && acc_wr;
    end

    // Capture the selected slave for read return and flag unmapped accesses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsel        <= RSEL_NONE;
            bus.bus_err <= 1'b0;
        end else begin
            rsel        <= {bus.s1_sel, bus.s0_sel};
            bus.bus_err <= acc_valid && !hit_s0 && !hit_s1;
        end
    end

    // Read data steering from the slave addressed last cycle
    always_comb begin
        case (rsel)
            RSEL_S0: bus.m_din = bus.s0_dout;
            RSEL_S1: bus.m_din = bus.s1_dout;
            default: bus.m_din = '0;
        endcase
    end

endmodule

// File: doc/dmac_bus.md
# dmac_bus

Shared system bus serving the two bus masters of the DMAC subsystem: M0 (host/processor) and M1 (the DMAC master port). It arbitrates on a req/grant handshake, routes the granted master's address, write data and write strobe to one of two slaves (S0 memory, S1 DMAC register file), and returns read data one cycle later. It is the responder side of the DMAC's `m_req`/`m_grant` master interface.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `clk  in  1`: single clock, all state rising-edge.
- `reset  in  1`: asynchronous, active-high; clears all state.
- `m0_req  in  1`: M0 bus request.
- `m0_wr  in  1`: M0 write strobe (1 = write, 0 = read).
- `m0_addr  in  ADDR_W`: M0 address.
- `m0_dout  in  DATA_W`: M0 write data.
- `m0_grant  out  1`: M0 owns the bus.
- `m1_req  in  1`: M1 (DMAC) bus request.
- `m1_wr  in  1`: M1 write strobe.
- `m1_addr  in  ADDR_W`: M1 address.
- `m1_dout  in  DATA_W`: M1 write data.
- `m1_grant  out  1`: M1 owns the bus.
- `m_din  out  DATA_W`: read data returned to both masters.
- `s0_sel  out  1`: memory select.
- `s1_sel  out  1`: DMAC register-file select.
- `s_addr  out  ADDR_W`: address to slaves.
- `s_wr  out  1`: write strobe to slaves.
- `s_din  out  DATA_W`: write data to slaves.
- `s0_dout  in  DATA_W`: memory read data (valid cycle after select).
- `s1_dout  in  DATA_W`: register-file read data (valid cycle after select).
- `bus_err  out  1`: one-cycle pulse, access to unmapped address.

## Operation
- Arbiter FSM, states `GNT_M0`, `GNT_M1`; reset → `GNT_M0`.
  - `GNT_M0`: `m0_req=0 && m1_req=1` → `GNT_M1`; else stay.
  - `GNT_M1`: `m1_req=0` → `GNT_M0`; else stay. No preemption; M1 holds until it drops its request.
  - `m0_grant = (state==GNT_M0)`, `m1_grant = (state==GNT_M1)`. Moore outputs, exactly one high.
- Master mux, combinational from state: `s_addr`, `s_wr`, `s_din` take the granted master's signals.
- Access valid = granted master's `req`. With no valid access: `s0_sel=s1_sel=0`, `s_wr=0`.
- Decode (valid access only):
  - `s_addr[15:11]==0` (0x0000–0x07FF) → `s0_sel`.
  - `s_addr[15:5]==11'h780` (0xF000–0xF01F) → `s1_sel`.
  - Anything else is unmapped: no select, `bus_err` next cycle.
- Read return: a registered 2-bit `rsel` captures {s1_sel, s0_sel} on every cycle. `m_din = s0_dout` if `rsel==01`, `s1_dout` if `10`, else 0.
- `bus_err` is registered: set the cycle after a valid unmapped access (read or write), else 0.

## Timing
- Reset values: `m0_grant=1`, `m1_grant=0`, `rsel=0` (`m_din=0`), `bus_err=0`, selects/`s_wr=0`.
- Grant latency: one cycle. A request seen at edge N gives the grant visible after edge N.
- Write: same cycle as address.
- Read: data on `m_din` one cycle after address.
- Simultaneous requests in `GNT_M0` with `m0_req=1`: M0 keeps the bus. Simultaneous drop of `m1_req` and rise of `m0_req`: return to `GNT_M0`.
- Grant handover cycle: no select is driven by the losing master once its `req` is low, so no partial access.
- Reset mid-access: `reset` asserted while in `GNT_M1` forces `GNT_M0` immediately, clears `rsel` and `bus_err`.

## Structure
- Package `dmac_bus_pkg`: state enum (`GNT_M0`, `GNT_M1`), S0/S1 base and mask constants, `rsel` encoding.
- One sub-module `dmac_bus_arbiter` (FSM + grants). Decode and muxes stay in the top.

## Test plan
- Reset: hold `reset=1` → `m0_grant=1`, `m1_grant=0`, `m_din=0`, `bus_err=0`. Release with idle inputs → state unchanged.
- M0 write then read: M0 `req=1`, `wr=1`, addr 0xF002, data 0x1. Expect `s1_sel=1`, `s_din=0x1`. Then read 0xF002 with `s1_dout=0x1` → `m_din=0x1` one cycle later.
- Handover: M0 `req=0`, M1 `req=1`. Expect `m1_grant=1` after one edge. M1 reads 0x0010 with `s0_dout=0xA5` → `m_din=0xA5` next cycle. M1 `req=0` → `m0_grant=1` after one edge.
- Contention: `m0_req=m1_req=1` in `GNT_M0` for 5 cycles → `m0_grant` stays 1. Then `m0_req=0` → `m1_grant=1` next cycle.
- Unmapped: granted access to 0x4000 → `s0_sel=s1_sel=0`, `bus_err=1` for exactly one cycle, `m_din=0`.
- Reset during M1 ownership: `reset` pulse while `m1_grant=1` → `m0_grant=1` immediately, `rsel` cleared.
